// File: rtl/uart_transceiver.sv
// Full-duplex 8N1 UART: byte in via tx_valid (held off until the frame ends), byte out via rx_complete strobe.
// TX line follows acceptance by one cycle, tx_complete at +10*CLKS_PER_BIT+1; rx_complete ~9.5 bit times after start edge.
module uart_transceiver #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       UART_RX,
    output logic       UART_TX,
    output logic       rx_complete,
    output logic [7:0] rx_data,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_complete
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    // Start-bit recheck lands half a bit in, counting the IDLE detection cycle.
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP, TX_DONE} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH} rx_state_t;

    tx_state_t         tx_state_q, tx_state_d;
    logic [CW-1:0]     tx_cnt_q, tx_cnt_d;
    logic [2:0]        tx_bit_q, tx_bit_d;
    logic [7:0]        tx_shift_q, tx_shift_d;
    logic              tx_line_q, tx_line_d;
    logic              tx_done_q, tx_done_d;

    rx_state_t         rx_state_q, rx_state_d;
    logic [CW-1:0]     rx_cnt_q, rx_cnt_d;
    logic [2:0]        rx_bit_q, rx_bit_d;
    logic [7:0]        rx_shift_q, rx_shift_d;
    logic [7:0]        rx_data_q, rx_data_d;
    logic              rx_done_q, rx_done_d;
    logic              rx_meta_q, rx_sync_q;

    assign UART_TX     = tx_line_q;
    assign tx_complete = tx_done_q;
    assign rx_data     = rx_data_q;
    assign rx_complete = rx_done_q;

    always_ff @(posedge clock) begin
        if (!reset) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_line_q  <= 1'b1;
            tx_done_q  <= 1'b0;
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_data_q  <= '0;
            rx_done_q  <= 1'b0;
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_line_q  <= tx_line_d;
            tx_done_q  <= tx_done_d;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_data_q  <= rx_data_d;
            rx_done_q  <= rx_done_d;
            rx_meta_q  <= UART_RX;
            rx_sync_q  <= rx_meta_q;
        end
    end

    // Line and complete are registered from the current state, hence the one-cycle lag.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_line_d  = 1'b1;
        tx_done_d  = 1'b0;
        case (tx_state_q)
            TX_IDLE: begin
                if (tx_valid) begin
                    tx_shift_d = tx_data;
                    tx_bit_d   = '0;
                    tx_cnt_d   = '0;
                    tx_state_d = TX_START;
                end
            end
            TX_START: begin
                tx_line_d = 1'b0;
                if (tx_cnt_q == CNT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_state_d = TX_DATA;
                end else begin
                    tx_cnt_d = tx_cnt_q + CW'(1);
                end
            end
            TX_DATA: begin
                tx_line_d = tx_shift_q[0];
                if (tx_cnt_q == CNT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    if (tx_bit_q == 3'd7) begin
                        tx_state_d = TX_STOP;
                    end else begin
                        tx_bit_d = tx_bit_q + 3'd1;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + CW'(1);
                end
            end
            TX_STOP: begin
                if (tx_cnt_q == CNT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_state_d = TX_DONE;
                end else begin
                    tx_cnt_d = tx_cnt_q + CW'(1);
                end
            end
            TX_DONE: begin
                tx_done_d  = 1'b1;
                tx_state_d = TX_IDLE;
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_data_d  = rx_data_q;
        rx_done_d  = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (!rx_sync_q) begin
                    rx_cnt_d   = '0;
                    rx_state_d = RX_START;
                end
            end
            RX_START: begin
                if (rx_cnt_q == CNT_HALF) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
                end else begin
                    rx_cnt_d = rx_cnt_q + CW'(1);
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == CNT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = RX_STOP;
                    end else begin
                        rx_bit_d = rx_bit_q + 3'd1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + CW'(1);
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == CNT_LAST) begin
                    rx_cnt_d = '0;
                    if (rx_sync_q) begin
                        rx_data_d  = rx_shift_q;
                        rx_done_d  = 1'b1;
                        rx_state_d = RX_IDLE;
                    end else begin
                        rx_state_d = RX_WAIT_HIGH;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + CW'(1);
                end
            end
            RX_WAIT_HIGH: begin
                if (rx_sync_q) rx_state_d = RX_IDLE;
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_transceiver.sv
// Scoreboard bench for uart_transceiver at CLKS_PER_BIT=8: stimulus queues expected frames/bytes, monitors check them.
module tb_uart_transceiver;

    typedef struct {
        logic [7:0] d;
        int         t;
    } item_t;

    logic       clock;
    logic       reset;
    logic       rx_line;
    logic       rx_drv;
    logic       loop_en;
    logic       UART_TX;
    logic       rx_complete;
    logic [7:0] rx_data;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_complete;

    int    cyc;
    int    total;
    int    bad;
    bit    mon_en;
    item_t exp_tx_q[$];
    item_t exp_rx_q[$];

    assign rx_line = loop_en ? UART_TX : rx_drv;

    uart_transceiver #(.CLKS_PER_BIT(8)) dut (
        .clock       (clock),
        .reset       (reset),
        .UART_RX     (rx_line),
        .UART_TX     (UART_TX),
        .rx_complete (rx_complete),
        .rx_data     (rx_data),
        .tx_valid    (tx_valid),
        .tx_data     (tx_data),
        .tx_complete (tx_complete)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [79:0] frame_wave(input logic [7:0] d);
        logic [9:0]  fr;
        logic [79:0] w;
        fr = {1'b1, d, 1'b0};
        for (int i = 0; i < 80; i++) w[i] = fr[i / 8];
        return w;
    endfunction

    // TX monitor: checks start cycle, the full 80-cycle line waveform, and the complete pulse position.
    bit          tx_busy;
    int          tx_start_c;
    item_t       tx_cur;
    logic [79:0] tx_got;

    always @(negedge clock) begin
        if (mon_en) begin
            if (!tx_busy && UART_TX === 1'b0) begin
                total++;
                if (exp_tx_q.size() == 0) begin
                    bad++;
                    $display("FAIL tx_start: unexpected frame at cycle %0d", cyc);
                    tx_cur = '{8'h00, cyc};
                end else begin
                    tx_cur = exp_tx_q.pop_front();
                    if (cyc != tx_cur.t) begin
                        bad++;
                        $display("FAIL tx_start: got cycle %0d expected %0d", cyc, tx_cur.t);
                    end
                end
                tx_busy    = 1'b1;
                tx_start_c = cyc;
            end
            if (tx_busy && (cyc - tx_start_c) < 80) begin
                tx_got[cyc - tx_start_c] = UART_TX;
                if (cyc - tx_start_c == 79) begin
                    total++;
                    if (tx_got !== frame_wave(tx_cur.d)) begin
                        bad++;
                        $display("FAIL tx_wave: got %h expected %h (byte %h)",
                                 tx_got, frame_wave(tx_cur.d), tx_cur.d);
                    end
                end
            end
            if (tx_complete === 1'b1) begin
                total++;
                if (!tx_busy || cyc != tx_start_c + 80) begin
                    bad++;
                    $display("FAIL tx_done: pulse at cycle %0d expected %0d (busy=%0d)",
                             cyc, tx_start_c + 80, tx_busy);
                end
                tx_busy = 1'b0;
            end else if (tx_busy && cyc >= tx_start_c + 80) begin
                total++;
                bad++;
                $display("FAIL tx_done: no pulse at cycle %0d expected %0d", cyc, tx_start_c + 80);
                tx_busy = 1'b0;
            end
        end
    end

    // RX monitor: every strobe must match the next queued byte within +-1 cycle of its expected time.
    always @(negedge clock) begin
        if (mon_en && rx_complete === 1'b1) begin
            total++;
            if (exp_rx_q.size() == 0) begin
                bad++;
                $display("FAIL rx_unexpected: strobe at cycle %0d data %h", cyc, rx_data);
            end else begin
                item_t it;
                it = exp_rx_q.pop_front();
                if (rx_data !== it.d) begin
                    bad++;
                    $display("FAIL rx_data: got %h expected %h", rx_data, it.d);
                end
                total++;
                if (cyc < it.t - 1 || cyc > it.t + 1) begin
                    bad++;
                    $display("FAIL rx_time: got cycle %0d expected %0d+-1", cyc, it.t);
                end
            end
        end
    end

    task automatic send_tx(input logic [7:0] b, input bit expect_rx);
        @(negedge clock);
        tx_valid = 1'b1;
        tx_data  = b;
        exp_tx_q.push_back('{b, cyc + 2});
        if (expect_rx) exp_rx_q.push_back('{b, cyc + 2 + 79});
        @(negedge clock);
        tx_valid = 1'b0;
    endtask

    task automatic rx_frame(input logic [7:0] b, input logic stop_bit, input bit expect_rx);
        logic [9:0] fr;
        fr = {stop_bit, b, 1'b0};
        @(negedge clock);
        if (expect_rx) exp_rx_q.push_back('{b, cyc + 79});
        for (int i = 0; i < 10; i++) begin
            rx_drv = fr[i];
            repeat (8) @(negedge clock);
        end
        rx_drv = 1'b1;
    endtask

    initial begin
        bit seen;
        total    = 0;
        bad      = 0;
        mon_en   = 1'b0;
        tx_busy  = 1'b0;
        reset    = 1'b0;
        tx_valid = 1'b1;
        tx_data  = 8'hA5;
        rx_drv   = 1'b1;
        loop_en  = 1'b0;

        // Reset held for two cycles with a pending request: line stays idle, no strobes.
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            total++;
            if ({UART_TX, tx_complete, rx_complete, rx_data} !== {1'b1, 1'b0, 1'b0, 8'h00}) begin
                bad++;
                $display("FAIL reset_state: got tx=%b txc=%b rxc=%b rxd=%h expected tx=1 txc=0 rxc=0 rxd=00",
                         UART_TX, tx_complete, rx_complete, rx_data);
            end
        end
        // Release: accepted on the next edge, so line falls two cycles on.
        reset  = 1'b1;
        mon_en = 1'b1;
        exp_tx_q.push_back('{8'hA5, cyc + 2});

        // Back-to-back: swap data while tx_complete is up, second frame 82 cycles after the first.
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clock);
            if (tx_complete === 1'b1) seen = 1'b1;
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL tx_wait: tx_complete got none expected within 200 cycles");
        end
        tx_data = 8'h3C;
        exp_tx_q.push_back('{8'h3C, cyc + 2});
        repeat (5) @(negedge clock);
        tx_valid = 1'b0;
        repeat (100) @(negedge clock);

        // Loopback.
        loop_en = 1'b1;
        send_tx(8'h00, 1'b1);
        repeat (90) @(negedge clock);
        send_tx(8'hFF, 1'b1);
        repeat (90) @(negedge clock);
        send_tx(8'h55, 1'b1);
        repeat (90) @(negedge clock);
        loop_en = 1'b0;
        repeat (5) @(negedge clock);

        // Glitch, then a real frame.
        rx_drv = 1'b0;
        repeat (2) @(negedge clock);
        rx_drv = 1'b1;
        repeat (20) @(negedge clock);
        rx_frame(8'h81, 1'b1, 1'b1);
        repeat (20) @(negedge clock);

        // Framing error leaves rx_data alone; next good frame is received.
        rx_frame(8'h12, 1'b0, 1'b0);
        repeat (20) @(negedge clock);
        total++;
        if (rx_data !== 8'h81) begin
            bad++;
            $display("FAIL rx_hold: got %h expected 81", rx_data);
        end
        rx_frame(8'h34, 1'b1, 1'b1);
        repeat (40) @(negedge clock);

        total++;
        if (exp_tx_q.size() != 0 || tx_busy) begin
            bad++;
            $display("FAIL tx_pending: got %0d queued busy=%0d expected 0 queued idle",
                     exp_tx_q.size(), tx_busy);
        end
        total++;
        if (exp_rx_q.size() != 0) begin
            bad++;
            $display("FAIL rx_pending: got %0d queued expected 0", exp_rx_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
